ram_fifo_sc: RTL and testbench



---
 rtl/ram_fifo_pkg.sv | 18 +
 rtl/ram_sdp_sync.sv | 26 ++
 rtl/ram_fifo_sc.sv | 152 +++++++++++++++
 tb/tb_ram_fifo_sc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared types and constants for the single-clock RAM FIFO family.
// The output-stage enum is only referenced when RAM_FIFO_FWFT_EN is defined.
package ram_fifo_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } out_state_t;

    localparam int DEFAULT_ALMOST_EMPTY       = 4;
    localparam int DEFAULT_ALMOST_FULL_MARGIN = 4;

    // Level must be able to hold the value depth itself, hence one extra bit.
    function automatic int level_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/ram_sdp_sync.sv
// Simple-dual-port RAM with one write port and one registered read port.
// Read latency is one cycle; the array has no reset so it infers block RAM.
module ram_sdp_sync #(
    parameter int data_width = 16,
    parameter int addr_bits  = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_bits-1:0]  waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [addr_bits-1:0]  raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [2**addr_bits];

    // rdata only changes on a read, so it holds the last word between reads.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_fifo_sc.sv
// Single-clock FIFO on an inferred SDP block RAM with level, thresholds and sticky errors.
// Define RAM_FIFO_FWFT_EN for first-word-fall-through output; default is standard read mode.
module ram_fifo_sc
    import ram_fifo_pkg::*;
#(
    parameter int data_width_int   = 16,
    parameter int addr_int         = 9,
    parameter int almost_full_int  = 2**addr_int - DEFAULT_ALMOST_FULL_MARGIN,
    parameter int almost_empty_int = DEFAULT_ALMOST_EMPTY
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic                               Clr,
    input  logic                               Push,
    input  logic [data_width_int-1:0]          Push_Data,
    input  logic                               Pop,
    output logic [data_width_int-1:0]          Pop_Data,
    output logic                               Pop_Valid,
    output logic                               Full,
    output logic                               Empty,
    output logic                               Almost_Full,
    output logic                               Almost_Empty,
    output logic [level_width(addr_int)-1:0]   Level,
    output logic                               Overflow,
    output logic                               Underflow
);

    localparam int DEPTH = 2**addr_int;
    localparam int LW    = level_width(addr_int);

    logic [addr_int-1:0]       wr_ptr;
    logic [addr_int-1:0]       rd_ptr;
    logic [LW-1:0]             level_q;
    logic                      push_ok;
    logic                      pop_ok;
    logic                      ram_re;
    logic                      ram_we;
    logic [data_width_int-1:0] ram_rdata;
    logic                      data_seen;

    assign Level        = level_q;
    assign Full         = (level_q == LW'(DEPTH));
    assign Empty        = (level_q == '0);
    assign Almost_Full  = (level_q >= LW'(almost_full_int));
    assign Almost_Empty = (level_q <= LW'(almost_empty_int));

    // A push into a full FIFO still fits when the head word leaves this cycle.
    assign push_ok = Push && (!Full || pop_ok);
    assign ram_we  = push_ok && !Clr;

`ifdef RAM_FIFO_FWFT_EN
    out_state_t    st_q;
    out_state_t    st_d;
    logic          fetch;
    logic [LW-1:0] stage_cnt;
    logic          ram_nonempty;

    assign Pop_Valid    = (st_q == VALID);
    assign pop_ok       = Pop && (st_q == VALID);
    assign stage_cnt    = (st_q == VALID) ? LW'(1) : '0;
    assign ram_nonempty = (level_q > stage_cnt);
    assign ram_re       = fetch;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            st_q <= EMPTY;
        else
            st_q <= st_d;
    end

    // Refill the stage whenever it is free or being acknowledged, so acks never bubble.
    always_comb begin
        st_d  = st_q;
        fetch = 1'b0;
        if (Clr) begin
            st_d = EMPTY;
        end else if (ram_nonempty && (st_q == EMPTY || pop_ok)) begin
            fetch = 1'b1;
            st_d  = VALID;
        end else if (pop_ok) begin
            st_d = EMPTY;
        end
    end
`else
    logic valid_q;

    assign pop_ok    = Pop && !Empty;
    assign ram_re    = pop_ok && !Clr;
    assign Pop_Valid = valid_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            valid_q <= 1'b0;
        else
            valid_q <= ram_re;
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (Clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (ram_re)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (Push && !push_ok)
                Overflow <= 1'b1;
            if (Pop && !pop_ok)
                Underflow <= 1'b1;
        end
    end

    // The RAM output register has no reset, so mask it until a word has been read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            data_seen <= 1'b0;
        else if (ram_re)
            data_seen <= 1'b1;
    end

    assign Pop_Data = data_seen ? ram_rdata : '0;

    ram_sdp_sync #(
        .data_width (data_width_int),
        .addr_bits  (addr_int)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (Push_Data),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ram_fifo_sc.sv
// Directed bench for ram_fifo_sc in its default (standard read) build.
// A vector table covers short mixed traffic; hand-written sequences cover fill, drain, thresholds, reset and clear.
module tb_ram_fifo_sc;

    logic        Clk       = 1'b0;
    logic        Rst_n     = 1'b0;
    logic        Clr       = 1'b0;
    logic        Push      = 1'b0;
    logic        Pop       = 1'b0;
    logic [15:0] Push_Data = 16'h0;
    logic [15:0] Pop_Data;
    logic        Pop_Valid;
    logic        Full;
    logic        Empty;
    logic        Almost_Full;
    logic        Almost_Empty;
    logic [9:0]  Level;
    logic        Overflow;
    logic        Underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] data;
        int          level;
        logic        empty;
        logic        full;
        logic        pv;
        logic [15:0] pdata;
        logic        ae;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [8];

    ram_fifo_sc dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Clr          (Clr),
        .Push         (Push),
        .Push_Data    (Push_Data),
        .Pop          (Pop),
        .Pop_Data     (Pop_Data),
        .Pop_Valid    (Pop_Valid),
        .Full         (Full),
        .Empty        (Empty),
        .Almost_Full  (Almost_Full),
        .Almost_Empty (Almost_Empty),
        .Level        (Level),
        .Overflow     (Overflow),
        .Underflow    (Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
    task automatic applyStimulus(input logic push, input logic pop, input logic clr, input logic [15:0] data);
        Push      = push;
        Pop       = pop;
        Clr       = clr;
        Push_Data = data;
        @(posedge Clk);
        #1;
        Push = 1'b0;
        Pop  = 1'b0;
        Clr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h00A1, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h00B2, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h00C3, 1, 1'b0, 1'b0, 1'b1, 16'h00B2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 16'h00B2, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b1, 16'h00C3, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h00C3, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 16'h00D4, 1, 1'b0, 1'b0, 1'b0, 16'h00C3, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        checkOutput("reset Level", int'(Level), 0);
        checkOutput("reset Empty", int'(Empty), 1);
        checkOutput("reset Almost_Empty", int'(Almost_Empty), 1);
        checkOutput("reset Full", int'(Full), 0);
        checkOutput("reset Almost_Full", int'(Almost_Full), 0);
        checkOutput("reset Pop_Valid", int'(Pop_Valid), 0);
        checkOutput("reset Pop_Data", int'(Pop_Data), 0);
        checkOutput("reset Overflow", int'(Overflow), 0);
        checkOutput("reset Underflow", int'(Underflow), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Vector table: mixed push/pop traffic including an empty push+pop
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].push, vecs[v].pop, 1'b0, vecs[v].data);
            checkOutput($sformatf("vec%0d Level", v), int'(Level), vecs[v].level);
            checkOutput($sformatf("vec%0d Empty", v), int'(Empty), int'(vecs[v].empty));
            checkOutput($sformatf("vec%0d Full", v), int'(Full), int'(vecs[v].full));
            checkOutput($sformatf("vec%0d Pop_Valid", v), int'(Pop_Valid), int'(vecs[v].pv));
            checkOutput($sformatf("vec%0d Pop_Data", v), int'(Pop_Data), int'(vecs[v].pdata));
            checkOutput($sformatf("vec%0d Almost_Empty", v), int'(Almost_Empty), int'(vecs[v].ae));
            checkOutput($sformatf("vec%0d Overflow", v), int'(Overflow), int'(vecs[v].ovf));
            checkOutput($sformatf("vec%0d Underflow", v), int'(Underflow), int'(vecs[v].unf));
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
        checkOutput("clr Level", int'(Level), 0);
        checkOutput("clr Empty", int'(Empty), 1);
        checkOutput("clr Underflow", int'(Underflow), 0);

        // Fill with 0..511 and watch the threshold boundaries on the way
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
            checkOutput("fill Level", int'(Level), i + 1);
            if (i + 1 == 4)   checkOutput("Almost_Empty at 4", int'(Almost_Empty), 1);
            if (i + 1 == 5)   checkOutput("Almost_Empty at 5", int'(Almost_Empty), 0);
            if (i + 1 == 507) checkOutput("Almost_Full at 507", int'(Almost_Full), 0);
            if (i + 1 == 508) checkOutput("Almost_Full at 508", int'(Almost_Full), 1);
            if (i + 1 == 511) checkOutput("Full at 511", int'(Full), 0);
        end
        checkOutput("Full at 512", int'(Full), 1);
        checkOutput("Overflow before 513th push", int'(Overflow), 0);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF);
        checkOutput("Overflow after 513th push", int'(Overflow), 1);
        checkOutput("Level after 513th push", int'(Level), 512);
        checkOutput("Full after 513th push", int'(Full), 1);

        // Drain: data must come out 0..511, one cycle after each pop
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput("drain Pop_Valid", int'(Pop_Valid), 1);
            checkOutput("drain Pop_Data", int'(Pop_Data), i);
        end
        checkOutput("Empty after drain", int'(Empty), 1);
        checkOutput("Underflow after drain", int'(Underflow), 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checkOutput("Underflow after 513th pop", int'(Underflow), 1);
        checkOutput("Pop_Valid after 513th pop", int'(Pop_Valid), 0);
        checkOutput("Pop_Data held after 513th pop", int'(Pop_Data), 511);

        // Full FIFO with simultaneous push and pop for 10 cycles
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 512; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h1000 + i));
        checkOutput("refill Level", int'(Level), 512);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'(16'h2000 + k));
            checkOutput("full push+pop Level", int'(Level), 512);
            checkOutput("full push+pop Overflow", int'(Overflow), 0);
            checkOutput("full push+pop Pop_Valid", int'(Pop_Valid), 1);
            checkOutput("full push+pop Pop_Data", int'(Pop_Data), 16'h1000 + k);
        end
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
            checkOutput("order Pop_Data", int'(Pop_Data),
                        (i < 502) ? (16'h1000 + 10 + i) : (16'h2000 + i - 502));
        end
        checkOutput("Empty after order drain", int'(Empty), 1);

        // Asynchronous reset in the middle of traffic at Level 100
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0100);
        checkOutput("pre-reset Level", int'(Level), 100);
        checkOutput("pre-reset Pop_Valid", int'(Pop_Valid), 1);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("async reset Level", int'(Level), 0);
        checkOutput("async reset Empty", int'(Empty), 1);
        checkOutput("async reset Pop_Valid", int'(Pop_Valid), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Same burst, but stopped with a synchronous clear
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0100);
        checkOutput("pre-clr Pop_Valid", int'(Pop_Valid), 1);
        checkOutput("pre-clr Pop_Data", int'(Pop_Data), 0);
        Clr  = 1'b1;
        Push = 1'b1;
        Pop  = 1'b1;
        #1;
        checkOutput("clr not yet applied Level", int'(Level), 100);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0200);
        checkOutput("sync clr Level", int'(Level), 0);
        checkOutput("sync clr Empty", int'(Empty), 1);
        checkOutput("sync clr Pop_Valid", int'(Pop_Valid), 0);
        checkOutput("sync clr Underflow", int'(Underflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
